bus_capture: RTL and testbench
==============================

BUS_CAPTURE -- requirements
Module: bus_capture

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 phi2  input  1  cartridge-bus phase-2 clock, asynchronous to clk.
REQ-004 addr  input  16  bus address.
REQ-005 data  input  8  bus data.
REQ-006 rw_n, s4_n, s5_n, cctl_n, D1xx_n, extsel_n, mpd_n, ref_n, irq_n, halt_n, rd4, rd5  input  1 each  bus control lines.
REQ-007 arm  input  1  single-cycle pulse; starts a capture session.
REQ-008 abort  input  1  single-cycle pulse; ends the session immediately.
REQ-009 cap_len  input  8  records per session; 0 means 256.
REQ-010 trig_addr  input  16  trigger address (see Configuration).
REQ-011 out_data  output  40  record {seq[3:0], rd5, rd4, halt_n, irq_n, ref_n, mpd_n, extsel_n, D1xx_n, cctl_n, s5_n, s4_n, rw_n, data, addr}.
REQ-012 out_valid  output  1  out_data holds a record.
REQ-013 out_ready  input  1  consumer accepts the record.
REQ-014 state  output  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
REQ-015 overflow  output  1  sticky; one or more records were dropped.

Function
REQ-016 phi2 SHALL pass through a 2-flop synchronizer; a bus event is a 1-to-0 transition on the synchronized value, detected one clk later.
REQ-017 All bus inputs SHALL be registered every clk; an event SHALL latch the registered values from the same clk as the detected falling edge.
REQ-018 IDLE -> ARMED on arm; ARMED -> CAPTURE on the qualifying event; CAPTURE -> DONE after cap_len records are written or dropped; DONE -> IDLE once the FIFO is empty; any state -> IDLE on abort.
REQ-019 The qualifying event SHALL itself be the first captured record.
REQ-020 arm in any state other than IDLE SHALL be ignored; arm and abort in the same cycle SHALL resolve as abort.
REQ-021 Records SHALL enter a 16-entry FIFO; out_valid = FIFO not empty; pop when out_valid and out_ready.
REQ-022 An event while the FIFO is full and no pop occurs in that cycle SHALL drop the record, set overflow, and still count toward cap_len.
REQ-023 Push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-024 seq SHALL be a 4-bit counter, cleared on arm and incremented per event (including drops), wrapping 15 -> 0.
REQ-025 The first record reaches out_valid 4 clk after the phi2 falling edge (2 sync, 1 detect, 1 write).
REQ-026 abort SHALL flush the FIFO in the same cycle and leave overflow unchanged.
REQ-027 overflow SHALL clear only on arm or reset.
REQ-028 cap_len SHALL be sampled on arm; later changes SHALL not affect the session.

Reset
REQ-029 Reset SHALL force state = IDLE, out_valid = 0, out_data = 0, overflow = 0, seq = 0, FIFO empty, and synchronizer flops = 1.
REQ-030 Reset asserted mid-session SHALL discard all buffered records without emitting a partial record.

Configuration
REQ-031 With BUS_CAPTURE_TRIGGER_EN defined, the ARMED -> CAPTURE transition SHALL need an event whose addr equals trig_addr, sampled on arm.
REQ-032 Without BUS_CAPTURE_TRIGGER_EN, the first event after arm SHALL qualify, and trig_addr SHALL be ignored.

Verification
REQ-033 cap_len=3, out_ready=1, 5 phi2 cycles with addr 0xA000..0xA004 -> 3 records, addr 0xA000..0xA002, seq 0..2; state reaches DONE, then IDLE.
REQ-034 TRIGGER_EN, trig_addr=0xD500, events addr 0xD4FF, 0xD500, 0xD501 with cap_len=2 -> records 0xD500 and 0xD501 only.
REQ-035 cap_len=20, out_ready=0 -> 16 records held, 4 dropped, overflow=1; releasing out_ready yields seq 0..15 in order.
REQ-036 abort after 2 records of a cap_len=10 session -> same cycle: state=IDLE, out_valid=0; the next arm clears overflow.
REQ-037 rst_n pulsed low mid-CAPTURE with 5 buffered records -> out_valid=0 and state=IDLE immediately, with no clk edge needed.
REQ-038 cap_len=0, 300 events -> exactly 256 records; seq wraps 15 -> 0 sixteen times.

Source files
------------

// File: rtl/bus_capture.sv
// Cartridge-bus capture: samples bus lines on each phi2 falling edge and buffers records in a 16-entry FIFO.
// Optional macro BUS_CAPTURE_TRIGGER_EN: session starts only on an event whose addr matches trig_addr.
module bus_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phi2,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        rw_n,
  input  logic        s4_n,
  input  logic        s5_n,
  input  logic        cctl_n,
  input  logic        D1xx_n,
  input  logic        extsel_n,
  input  logic        mpd_n,
  input  logic        ref_n,
  input  logic        irq_n,
  input  logic        halt_n,
  input  logic        rd4,
  input  logic        rd5,
  input  logic        arm,
  input  logic        abort,
  input  logic [7:0]  cap_len,
  input  logic [15:0] trig_addr,
  output logic [39:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  state,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      cur_state, next_state;

  logic        phi2_s1, phi2_s2, phi2_s3;
  logic        fall;
  logic        ev_q;
  logic [35:0] bus_q;
  logic [35:0] ev_rec;

  logic [8:0]  sess_len;
  logic [8:0]  rec_cnt;
  logic [3:0]  seq;
  logic        qualify;
  logic        take;
  logic        last;
  logic        start;

  logic [39:0] mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [4:0]  fifo_cnt;
  logic        full;
  logic        push, pop, drop;

  // phi2 synchronizer; s3 is the previous synchronized value used for edge detect
  assign fall = phi2_s3 & ~phi2_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi2_s1 <= 1'b1;
      phi2_s2 <= 1'b1;
      phi2_s3 <= 1'b1;
      ev_q    <= 1'b0;
      bus_q   <= '0;
      ev_rec  <= '0;
    end else begin
      phi2_s1 <= phi2;
      phi2_s2 <= phi2_s1;
      phi2_s3 <= phi2_s2;
      bus_q   <= {rd5, rd4, halt_n, irq_n, ref_n, mpd_n, extsel_n, D1xx_n,
                  cctl_n, s5_n, s4_n, rw_n, data, addr};
      ev_q    <= fall;
      if (fall) ev_rec <= bus_q;
    end
  end

`ifdef BUS_CAPTURE_TRIGGER_EN
  logic [15:0] trig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     trig_q <= '0;
    else if (start) trig_q <= trig_addr;
  end

  assign qualify = (ev_rec[15:0] == trig_q);
`else
  logic unused_trig;
  assign unused_trig = ^trig_addr;
  assign qualify     = 1'b1;
`endif

  assign start = arm & ~abort & (cur_state == S_IDLE);
  assign take  = ev_q & ~abort &
                 (((cur_state == S_ARMED) & qualify) | (cur_state == S_CAPTURE));
  assign last  = take & ((rec_cnt + 9'd1) == sess_len);

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IDLE:    if (arm) next_state = S_ARMED;
      S_ARMED:   if (take) next_state = last ? S_DONE : S_CAPTURE;
      S_CAPTURE: if (last) next_state = S_DONE;
      S_DONE:    if (fifo_cnt == 5'd0) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_IDLE;
    else        cur_state <= next_state;
  end

  // Session bookkeeping: dropped records still consume a sequence number and length slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sess_len <= 9'd0;
      rec_cnt  <= 9'd0;
      seq      <= 4'd0;
      overflow <= 1'b0;
    end else if (start) begin
      sess_len <= (cap_len == 8'd0) ? 9'd256 : {1'b0, cap_len};
      rec_cnt  <= 9'd0;
      seq      <= 4'd0;
      overflow <= 1'b0;
    end else if (take) begin
      rec_cnt <= rec_cnt + 9'd1;
      seq     <= seq + 4'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign full      = (fifo_cnt == 5'd16);
  assign out_valid = (fifo_cnt != 5'd0);
  assign pop       = out_valid & out_ready;
  assign push      = take & (~full | pop);
  assign drop      = take & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      fifo_cnt <= 5'd0;
    end else if (abort) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      fifo_cnt <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {seq, ev_rec};
  end

  // Storage is not reset, so the output is gated to read zero while empty
  assign out_data = out_valid ? mem[rd_ptr] : 40'd0;
  assign state    = cur_state;

endmodule

// File: tb/tb_bus_capture.sv
// Self-checking bench for bus_capture: table of capture sessions plus hand-written
// sequences for latency, abort, trigger qualification and mid-session reset.
module tb_bus_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        phi2 = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  data = '0;
  logic [11:0] ctl = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cap_len = '0;
  logic [15:0] trig_addr = '0;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  state;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int n_pop = 0;
  bit saw_done = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  bus_capture dut (
    .clk(clk), .rst_n(rst_n), .phi2(phi2), .addr(addr), .data(data),
    .rw_n(ctl[0]), .s4_n(ctl[1]), .s5_n(ctl[2]), .cctl_n(ctl[3]),
    .D1xx_n(ctl[4]), .extsel_n(ctl[5]), .mpd_n(ctl[6]), .ref_n(ctl[7]),
    .irq_n(ctl[8]), .halt_n(ctl[9]), .rd4(ctl[10]), .rd5(ctl[11]),
    .arm(arm), .abort(abort), .cap_len(cap_len), .trig_addr(trig_addr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .state(state), .overflow(overflow)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every accepted record is compared against the head of exp_q
  always @(negedge clk) begin
    if (state == 2'd3) saw_done = 1;
    if (rst_n && out_valid && out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record: got %h expected none", out_data);
      end else begin
        check("record", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic arm_session(input logic [7:0] len, input logic [15:0] t);
    @(posedge clk); #1;
    saw_done = 0;
    n_pop = 0;
    arm = 1'b1; cap_len = len; trig_addr = t;
    @(posedge clk); #1;
    arm = 1'b0;
    cap_len = 8'($urandom_range(1, 255));
  endtask

  task automatic bus_event(input logic [15:0] a, input bit want, input logic [3:0] sq);
    logic [7:0]  d;
    logic [11:0] c;
    d = 8'($urandom_range(0, 255));
    c = 12'($urandom_range(0, 4095));
    if (want) exp_q.push_back({sq, c, d, a});
    @(posedge clk); #1;
    addr = a; data = d; ctl = c; phi2 = 1'b1;
    repeat (4) @(posedge clk);
    #1 phi2 = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic finish_session(input string name, input int exp_n, input logic exp_ovf);
    bit done = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && state == 2'd0) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout: left=%0d state=%0d expected empty/IDLE", name, exp_q.size(), state);
      exp_q.delete();
    end
    check({name, "_count"}, 40'(n_pop), 40'(exp_n));
    check({name, "_overflow"}, 40'(overflow), 40'(exp_ovf));
    check({name, "_state"}, 40'(state), 40'd0);
  endtask

  typedef struct {
    logic [7:0]  cap_len;
    int          n_ev;
    logic [15:0] base;
    bit          ready;
    int          exp_n;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'd3,  5,   16'hA000, 1'b1, 3,   1'b0};
    vecs[1] = '{8'd20, 20,  16'h1000, 1'b0, 16,  1'b1};
    vecs[2] = '{8'd1,  2,   16'h2000, 1'b1, 1,   1'b0};
    vecs[3] = '{8'd16, 16,  16'h4000, 1'b0, 16,  1'b0};
    vecs[4] = '{8'd17, 17,  16'h5000, 1'b0, 16,  1'b1};
    vecs[5] = '{8'd0,  300, 16'h6000, 1'b1, 256, 1'b0};

    #23;
    check("rst_state", 40'(state), 40'd0);
    check("rst_valid", 40'(out_valid), 40'd0);
    check("rst_data", out_data, 40'd0);
    check("rst_overflow", 40'(overflow), 40'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // First record appears exactly 4 clk edges after the phi2 fall
    out_ready = 1'b0;
    arm_session(8'd1, 16'h0);
    check("armed_state", 40'(state), 40'd1);
    addr = 16'hBEEF; data = 8'h5A; ctl = 12'hA5C; phi2 = 1'b1;
    exp_q.push_back({4'd0, 12'hA5C, 8'h5A, 16'hBEEF});
    repeat (4) @(posedge clk);
    #1 phi2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("latency_edge%0d", k), 40'(out_valid), (k == 4) ? 40'd1 : 40'd0);
    end
    check("len1_done", 40'(state), 40'd3);
    phi2 = 1'b1;
    finish_session("latency", 1, 1'b0);

    foreach (vecs[vi]) begin
      int eff, kept;
      vec_t v;
      v = vecs[vi];
      out_ready = v.ready;
      arm_session(v.cap_len, 16'h0);
      eff = (v.cap_len == 8'd0) ? 256 : int'(v.cap_len);
      kept = 0;
      for (int i = 0; i < v.n_ev; i++) begin
        bit want;
        want = (i < eff) && (v.ready || kept < 16);
        if (want) kept++;
        bus_event(16'(v.base + i), want, 4'(i));
      end
      if (!v.ready) check($sformatf("vec%0d_done_state", vi), 40'(state), 40'd3);
      finish_session($sformatf("vec%0d", vi), v.exp_n, v.exp_ovf);
      check($sformatf("vec%0d_saw_done", vi), 40'(saw_done), 40'd1);
    end

    // Trigger qualification (trig_addr ignored unless the trigger feature is built in)
    out_ready = 1'b1;
    arm_session(8'd2, 16'hD500);
`ifdef BUS_CAPTURE_TRIGGER_EN
    bus_event(16'hD4FF, 1'b0, 4'd0);
    check("trig_still_armed", 40'(state), 40'd1);
    bus_event(16'hD500, 1'b1, 4'd0);
    bus_event(16'hD501, 1'b1, 4'd1);
`else
    bus_event(16'hD4FF, 1'b1, 4'd0);
    check("notrig_capture", 40'(state), 40'd2);
    bus_event(16'hD500, 1'b1, 4'd1);
    bus_event(16'hD501, 1'b0, 4'd0);
`endif
    finish_session("trigger", 2, 1'b0);

    // Abort mid-session with overflow set; a stray arm mid-session must be ignored
    out_ready = 1'b0;
    arm_session(8'd20, 16'h0);
    for (int i = 0; i < 18; i++) begin
      bus_event(16'(16'h3000 + i), i < 16, 4'(i));
      if (i == 1) begin
        @(posedge clk); #1 arm = 1'b1; cap_len = 8'd2;
        @(posedge clk); #1 arm = 1'b0;
      end
    end
    check("abort_pre_state", 40'(state), 40'd2);
    check("abort_pre_overflow", 40'(overflow), 40'd1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    check("abort_state", 40'(state), 40'd0);
    check("abort_valid", 40'(out_valid), 40'd0);
    check("abort_overflow_kept", 40'(overflow), 40'd1);
    @(posedge clk); #1 arm = 1'b1; abort = 1'b1; cap_len = 8'd5;
    @(posedge clk); #1 arm = 1'b0; abort = 1'b0;
    check("arm_abort_state", 40'(state), 40'd0);
    check("arm_abort_overflow", 40'(overflow), 40'd1);
    arm_session(8'd5, 16'h0);
    check("rearm_state", 40'(state), 40'd1);
    check("rearm_overflow_clear", 40'(overflow), 40'd0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_armed_state", 40'(state), 40'd0);

    // Asynchronous reset with records buffered
    out_ready = 1'b0;
    arm_session(8'd10, 16'h0);
    for (int i = 0; i < 5; i++) bus_event(16'(16'h7000 + i), 1'b1, 4'(i));
    check("prerst_valid", 40'(out_valid), 40'd1);
    check("prerst_state", 40'(state), 40'd2);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("midrst_state", 40'(state), 40'd0);
    check("midrst_valid", 40'(out_valid), 40'd0);
    check("midrst_data", out_data, 40'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("postrst_valid", 40'(out_valid), 40'd0);
    check("postrst_state", 40'(state), 40'd0);
    check("leftover_expected", 40'(exp_q.size()), 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
